// File: rtl/line_buffer_5x5.sv
// Producer side of a 5x5 window: four line delays turn one raster pixel stream into
// five vertically aligned row taps (S1 = row r-4 ... S5 = row r) for the window buffer.
module line_buffer_5x5 #(
  parameter int COLS       = 7,
  parameter int ROWS       = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] S1_o,
  output logic [DATA_WIDTH-1:0] S2_o,
  output logic [DATA_WIDTH-1:0] S3_o,
  output logic [DATA_WIDTH-1:0] S4_o,
  output logic [DATA_WIDTH-1:0] S5_o,
  output logic                  done_o,
  output logic                  progress_done_o,
  output logic                  fsm_state
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Handshake: a pixel is accepted on any rising edge with done_i=1 and rst=0; there is
  // no back-pressure. done_o=1 marks the cycle in which S1..S5 form a valid column.
  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   col;
  logic [CW-1:0]   col_next;
  logic [RW-1:0]   row;
  logic [RW-1:0]   row_next;
  logic            last_col;
  logic            last_row;
  logic            fill_row;
  logic            done_next;
  logic            prog_next;

  logic [DATA_WIDTH-1:0] l1 [COLS];
  logic [DATA_WIDTH-1:0] l2 [COLS];
  logic [DATA_WIDTH-1:0] l3 [COLS];
  logic [DATA_WIDTH-1:0] l4 [COLS];

  always_comb begin
    last_col = (col == CW'(COLS - 1));
    last_row = (row == RW'(ROWS - 1));
    fill_row = (row == RW'(3));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave FILL after the last pixel of row 3, return after the frame
  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (done_i && last_col && fill_row) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (done_i && last_col && last_row) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Output logic: values registered into done_o / progress_done_o on the next edge
  always_comb begin
    done_next = done_i && (state == STREAM);
    prog_next = done_next && last_col && last_row;
  end

  assign fsm_state = (state == STREAM);

  // Raster position; wrapping at the frame end lets the next pixel be (0,0) with no bubble
  always_comb begin
    col_next = col;
    row_next = row;
    if (done_i) begin
      if (last_col) begin
        col_next = '0;
        row_next = last_row ? '0 : row + RW'(1);
      end else begin
        col_next = col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col             <= '0;
      row             <= '0;
      done_o          <= 1'b0;
      progress_done_o <= 1'b0;
      S1_o            <= '0;
      S2_o            <= '0;
      S3_o            <= '0;
      S4_o            <= '0;
      S5_o            <= '0;
    end else begin
      col             <= col_next;
      row             <= row_next;
      done_o          <= done_next;
      progress_done_o <= prog_next;
      if (done_i) begin
        S5_o <= data_i;
        S4_o <= l4[col];
        S3_o <= l3[col];
        S2_o <= l2[col];
        S1_o <= l1[col];
      end
    end
  end

  // Line delays share the column pointer; each entry moves up one store per row.
  // Storage is deliberately not reset: stale entries only reach taps while done_o=0.
  always_ff @(posedge clk) begin
    if (done_i && !rst) begin
      l4[col] <= data_i;
      l3[col] <= l4[col];
      l2[col] <= l3[col];
      l1[col] <= l2[col];
    end
  end

endmodule

// File: tb/tb_line_buffer_5x5.sv
// Directed-sequence bench for line_buffer_5x5 with a frame-array reference model.
module tb_line_buffer_5x5;

  localparam int COLS = 7;
  localparam int ROWS = 7;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          done_i;
  logic [DW-1:0] data_i;
  logic [DW-1:0] S1_o, S2_o, S3_o, S4_o, S5_o;
  logic          done_o;
  logic          progress_done_o;
  logic          fsm_state;

  line_buffer_5x5 #(.COLS(COLS), .ROWS(ROWS), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .data_i(data_i),
    .S1_o(S1_o), .S2_o(S2_o), .S3_o(S3_o), .S4_o(S4_o), .S5_o(S5_o),
    .done_o(done_o), .progress_done_o(progress_done_o), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the pixels of the current frame, indexed by raster position
  logic [DW-1:0]   frame [ROWS][COLS];
  int              m_row;
  int              m_col;
  logic [5*DW-1:0] exp_q [$];
  logic [5*DW-1:0] held;
  bit              held_ok;
  int              n_done;
  int              n_prog;
  logic [5*DW-1:0] first_obs;
  logic [5*DW-1:0] last_obs;

  function automatic logic [5*DW-1:0] pack5(int a, int b, int c, int d, int e);
    return {DW'(a), DW'(b), DW'(c), DW'(d), DW'(e)};
  endfunction

  function automatic logic [5*DW-1:0] taps();
    return {S1_o, S2_o, S3_o, S4_o, S5_o};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict, then check just after the edge
  task automatic cycle(bit r, bit v, logic [DW-1:0] d);
    bit              exp_done;
    bit              exp_prog;
    bit              is_first;
    bit              is_last;
    logic [5*DW-1:0] exp_t;
    logic [5*DW-1:0] got;
    rst      = r;
    done_i   = v;
    data_i   = d;
    exp_done = 1'b0;
    exp_prog = 1'b0;
    is_first = (m_row == 4) && (m_col == 0);
    is_last  = (m_row == ROWS - 1) && (m_col == COLS - 1);
    if (!r && v) begin
      frame[m_row][m_col] = d;
      if (m_row >= 4) begin
        exp_done = 1'b1;
        exp_prog = is_last;
        exp_q.push_back({frame[m_row-4][m_col], frame[m_row-3][m_col],
                         frame[m_row-2][m_col], frame[m_row-1][m_col], d});
      end
    end
    @(posedge clk);
    #1;
    got = taps();
    n_done += int'(done_o);
    n_prog += int'(progress_done_o);
    chk("done_o", 64'(done_o), 64'(exp_done));
    chk("progress_done_o", 64'(progress_done_o), 64'(exp_prog));
    if (r) begin
      chk("reset_taps", 64'(got), 64'(0));
      chk("reset_state", 64'(fsm_state), 64'(0));
      m_row   = 0;
      m_col   = 0;
      held    = '0;
      held_ok = 1'b1;
    end else if (v) begin
      chk("S5_tap", 64'(S5_o), 64'(d));
      if (exp_done) begin
        exp_t = exp_q.pop_front();
        chk("window_taps", 64'(got), 64'(exp_t));
        held    = exp_t;
        held_ok = 1'b1;
        if (is_first) first_obs = got;
        if (is_last)  last_obs  = got;
      end else begin
        held_ok = 1'b0;
      end
      if (m_col == COLS - 1) begin
        m_col = 0;
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
      chk("fsm_state", 64'(fsm_state), 64'(m_row >= 4));
    end else if (held_ok) begin
      chk("held_taps", 64'(got), 64'(held));
    end
  endtask

  // Sends cnt pixels from the current model position, each preceded by 0..max_gap idle cycles
  task automatic send_pixels(int base, bit rnd, int max_gap, int cnt);
    logic [DW-1:0] px;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(max_gap, 0)) cycle(1'b0, 1'b0, DW'($urandom));
      px = rnd ? DW'($urandom) : DW'(base + m_row * COLS + m_col);
      cycle(1'b0, 1'b1, px);
    end
  endtask

  task automatic frame_check(string tag, int base);
    chk({tag, "_first"}, 64'(first_obs), 64'(pack5(base, base+7, base+14, base+21, base+28)));
    chk({tag, "_last"}, 64'(last_obs), 64'(pack5(base+20, base+27, base+34, base+41, base+48)));
    chk({tag, "_done_count"}, 64'(n_done), 64'((ROWS - 4) * COLS));
    chk({tag, "_prog_count"}, 64'(n_prog), 64'(1));
  endtask

  initial begin
    rst = 1'b1; done_i = 1'b1; data_i = '0;
    m_row = 0; m_col = 0; held = '0; held_ok = 1'b0;
    n_done = 0; n_prog = 0; first_obs = '0; last_obs = '0;

    // Reset held with done_i=1
    cycle(1'b1, 1'b1, DW'($urandom));
    cycle(1'b1, 1'b1, DW'($urandom));

    // Continuous frame, pix = r*7+c
    n_done = 0; n_prog = 0;
    send_pixels(0, 1'b0, 0, ROWS * COLS);
    frame_check("cont", 0);

    // Same frame with random gaps
    n_done = 0; n_prog = 0; first_obs = '0; last_obs = '0;
    send_pixels(0, 1'b0, 3, ROWS * COLS);
    frame_check("gapped", 0);

    // Back-to-back frame, no bubble
    n_done = 0; n_prog = 0; first_obs = '0; last_obs = '0;
    send_pixels(100, 1'b0, 0, ROWS * COLS);
    frame_check("b2b", 100);

    // Random pixel data with gaps, two frames
    n_done = 0; n_prog = 0;
    send_pixels(0, 1'b1, 2, 2 * ROWS * COLS);
    chk("rand_done_count", 64'(n_done), 64'(2 * (ROWS - 4) * COLS));
    chk("rand_prog_count", 64'(n_prog), 64'(2));

    // Abort after pixel (5,3), then a fresh frame
    n_done = 0; n_prog = 0;
    send_pixels(50, 1'b0, 1, 5 * COLS + 4);
    cycle(1'b1, 1'b1, DW'($urandom));
    chk("abort_done_count", 64'(n_done), 64'(COLS + 4));
    chk("abort_prog_count", 64'(n_prog), 64'(0));
    n_done = 0; n_prog = 0; first_obs = '0; last_obs = '0;
    send_pixels(0, 1'b0, 0, ROWS * COLS);
    frame_check("after_reset", 0);
    repeat (3) cycle(1'b0, 1'b0, '0);

    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
